crc_rx_checker: RTL and testbench
=================================

Name: crc_rx_checker

Overview:
- Downstream stage of the CRC-16 transmit port. Consumes the 32-bit codeword {data, crc} that the transmitter presents alongside its codeword-valid pulse.
- Recomputes the CRC serially, MSB first, through the same zero-initialised LFSR, then reports the recovered data with a pass/fail flag.
- Sits at the receive end of the link, in front of the consumer logic.

Parameters:
- DATA_W, 16, payload width in bits.
- CRC_W, 16, CRC width in bits; codeword width CW_W = DATA_W + CRC_W.
- POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term (x^16+x^12+x^5+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- cw_in  in  CW_W  codeword; data in [CW_W-1:CRC_W], crc in [CRC_W-1:0].
- cw_valid  in  1  single-cycle qualifier for cw_in.
- busy  out  1  high while a codeword is being checked; cw_valid is ignored while busy.
- data_out  out  DATA_W  recovered payload; holds its value between reports.
- data_valid  out  1  one-cycle pulse when data_out and crc_err are valid.
- crc_err  out  1  1 = remainder non-zero; valid with data_valid and holds until the next report.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register, LFSR and bit counter cleared.
  - busy=0, data_valid=0, crc_err=0, data_out=0.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - busy=0.
  - If cw_valid=1 at an edge (E0): capture cw_in into the shift register, clear the LFSR to 0, load the counter with CW_W-1, go to SHIFT.
- SHIFT:
  - busy=1.
  - Each edge: b = shift-register MSB; shift register moves left by one.
  - LFSR update: Q[0] <= b ^ Q[CRC_W-1]; for i=1..CRC_W-1, Q[i] <= Q[i-1] ^ (POLY[i] & Q[CRC_W-1]).
  - Counter decrements each edge. The edge that shifts with counter==0 is the CW_W-th shift (E32) and moves to REPORT.
- REPORT:
  - busy=1.
  - At the next edge (E33): data_out <= captured data field; crc_err <= (LFSR != 0); data_valid <= 1; state -> IDLE.
- Timing:
  - data_valid is high for exactly the one cycle following E33, i.e. 33 cycles after the capture edge with defaults.
  - data_valid is deasserted at the next edge.
- Throughput:
  - The earliest next capture is E34: one codeword per CW_W+2 cycles.
  - cw_valid seen in SHIFT or REPORT is dropped. No queueing, no error indication.
- cw_valid coincident with data_valid (state IDLE at that edge) is accepted normally.
- A codeword with all-zero data and crc checks clean (crc_err=0).
- Reset asserted mid-SHIFT or mid-REPORT:
  - Returns to IDLE immediately; no data_valid is generated for the aborted word.
  - crc_err and data_out are cleared.
- Widths: counter sized clog2(CW_W). All arithmetic is unsigned; the counter never wraps because the state exits at 0.

Optional Feature:
- Macro: CRC_ERR_CNT_EN.
- Defined: adds input err_cnt_clr (1 bit) and output err_cnt (16 bits).
  - err_cnt increments on each data_valid with crc_err=1 and saturates at 16'hFFFF.
  - err_cnt_clr=1 clears it synchronously and takes priority over an increment in the same cycle.
  - err_cnt resets to 0.
- Not defined: neither port exists and no counter logic is generated.

Test Plan:
- Reset, then cw_in=32'h0001_1021 with a cw_valid pulse -> busy=1 for 33 cycles; data_valid pulse 33 cycles after capture; data_out=16'h0001, crc_err=0.
- cw_in=32'h0003_3063 -> data_out=16'h0003, crc_err=0.
- cw_in=32'h0001_1020 (single bit flipped) -> data_out=16'h0001, crc_err=1.
- Capture 32'h0002_2042, pulse cw_valid at cycles 5 and 20 after capture -> both ignored; exactly one data_valid with data_out=16'h0002, crc_err=0.
- Drop rst for one cycle 10 cycles into SHIFT -> no data_valid; outputs 0. Then 32'h0000_0000 -> data_out=0, crc_err=0.
- With CRC_ERR_CNT_EN defined:
  - Three bad codewords (32'h0001_1020) -> err_cnt=3.
  - Then err_cnt_clr coincident with a fourth bad report -> err_cnt=0.

Source files
------------

// File: rtl/crc_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : crc_rx_checker
// Description : Receive-side CRC-16 checker. Captures a {data, crc} codeword,
//               pushes it MSB first through a zero-initialised serial LFSR and
//               reports the recovered payload with a pass/fail flag. A valid
//               codeword leaves a zero remainder.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//    clk            in   rising-edge clock
//    rst_n          in   asynchronous active-low reset
//    i_cw_in        in   codeword, data in [CW_W-1:CRC_W], crc in [CRC_W-1:0]
//    i_cw_valid     in   single-cycle qualifier for i_cw_in (ignored when busy)
//    o_busy         out  high while a codeword is being checked
//    o_data_out     out  recovered payload, held between reports
//    o_data_valid   out  one-cycle pulse marking a new report
//    o_crc_err      out  1 = non-zero remainder, held until the next report
// Optional (macro CRC_ERR_CNT_EN defined):
//    i_err_cnt_clr  in   synchronous clear of the error counter (wins over +1)
//    o_err_cnt      out  saturating count of failed reports
// ============================================================================
module crc_rx_checker #(
   parameter int               DATA_W = 16,
   parameter int               CRC_W  = 16,
   parameter logic [CRC_W-1:0] POLY   = 16'h1021
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_W+CRC_W-1:0]   i_cw_in,
   input  logic                      i_cw_valid,
   output logic                      o_busy,
   output logic [DATA_W-1:0]         o_data_out,
   output logic                      o_data_valid,
   output logic                      o_crc_err
`ifdef CRC_ERR_CNT_EN
   ,
   input  logic                      i_err_cnt_clr,
   output logic [15:0]               o_err_cnt
`endif
);

   localparam int CW_W  = DATA_W + CRC_W;
   localparam int CNT_W = $clog2(CW_W);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   state_t              r_state;
   logic [CW_W-1:0]     r_shift;
   logic [DATA_W-1:0]   r_data_cap;
   logic [CRC_W-1:0]    r_lfsr;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;
   logic [DATA_W-1:0]   r_data_out;
   logic                r_data_valid;
   logic                r_crc_err;

   logic [CRC_W-1:0]    w_lfsr_next;

   // Serial LFSR step: the incoming bit is folded into Q[0] rather than the
   // feedback tap, so the register holds M(x) mod P without augmentation and
   // a correct codeword ends with all zeros.
   always_comb begin
      w_lfsr_next    = '0;
      w_lfsr_next[0] = r_shift[CW_W-1] ^ r_lfsr[CRC_W-1];
      for (int i = 1; i < CRC_W; i++) begin
         w_lfsr_next[i] = r_lfsr[i-1] ^ (POLY[i] & r_lfsr[CRC_W-1]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_data_cap   <= '0;
         r_lfsr       <= '0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_crc_err    <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               if (i_cw_valid) begin
                  r_shift    <= i_cw_in;
                  r_data_cap <= i_cw_in[CW_W-1:CRC_W];
                  r_lfsr     <= '0;
                  r_cnt      <= CNT_W'(CW_W - 1);
                  r_busy     <= 1'b1;
                  r_state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_shift <= {r_shift[CW_W-2:0], 1'b0};
               r_lfsr  <= w_lfsr_next;
               // Counter stops at zero; that edge performs the last shift.
               if (r_cnt == '0) begin
                  r_state <= ST_REPORT;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_REPORT: begin
               r_data_out   <= r_data_cap;
               r_crc_err    <= |r_lfsr;
               r_data_valid <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_data_out   = r_data_out;
   assign o_data_valid = r_data_valid;
   assign o_crc_err    = r_crc_err;

`ifdef CRC_ERR_CNT_EN
   logic [15:0] r_err_cnt;

   // Counts on the cycle the failed report is visible; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (i_err_cnt_clr) begin
         r_err_cnt <= '0;
      end else if (r_data_valid && r_crc_err && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign o_err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_rx_checker
// Description : Directed self-checking bench for crc_rx_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_rx_checker;

   logic        clk;
   logic        rst_n;
   logic [31:0] i_cw_in;
   logic        i_cw_valid;
   logic        o_busy;
   logic [15:0] o_data_out;
   logic        o_data_valid;
   logic        o_crc_err;
   logic        i_err_cnt_clr;
`ifdef CRC_ERR_CNT_EN
   logic [15:0] o_err_cnt;
`endif

   int checks;
   int passes;

   crc_rx_checker u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cw_in      (i_cw_in),
      .i_cw_valid   (i_cw_valid),
      .o_busy       (o_busy),
      .o_data_out   (o_data_out),
      .o_data_valid (o_data_valid),
      .o_crc_err    (o_crc_err)
`ifdef CRC_ERR_CNT_EN
      ,
      .i_err_cnt_clr(i_err_cnt_clr),
      .o_err_cnt    (o_err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Sends one codeword and checks latency, busy window, report contents and
   // the absence of any extra report. Optional: drop stray cw_valid pulses at
   // 5 and 20 cycles after capture, or pulse err_cnt_clr alongside the report.
   task automatic run_word(input string tag, input logic [31:0] cw,
                           input logic [15:0] exp_data, input logic exp_err,
                           input bit inject, input bit clr_at_dv);
      int lat;
      int busy_cnt;
      int extra;
      i_cw_in    = cw;
      i_cw_valid = 1'b1;
      tick();
      i_cw_valid = 1'b0;
      lat        = 0;
      busy_cnt   = (o_busy === 1'b1) ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         if (inject && (k == 5 || k == 20)) begin
            i_cw_in    = 32'h0001_1020;
            i_cw_valid = 1'b1;
         end
         tick();
         i_cw_valid = 1'b0;
         if (o_data_valid === 1'b1) begin
            lat = k;
            break;
         end
         if (o_busy === 1'b1) busy_cnt++;
      end
      check({tag, " latency"}, lat, 33);
      check({tag, " busy_cycles"}, busy_cnt, 33);
      check({tag, " data_out"}, {16'h0, o_data_out}, {16'h0, exp_data});
      check({tag, " crc_err"}, {31'h0, o_crc_err}, {31'h0, exp_err});
      if (clr_at_dv) i_err_cnt_clr = 1'b1;
      tick();
      i_err_cnt_clr = 1'b0;
      check({tag, " dv_one_cycle"}, {31'h0, o_data_valid}, 32'h0);
      extra = 0;
      for (int k = 0; k < 45; k++) begin
         tick();
         if (o_data_valid === 1'b1) extra++;
      end
      check({tag, " extra_reports"}, extra, 0);
      check({tag, " hold_data"}, {16'h0, o_data_out}, {16'h0, exp_data});
   endtask

   initial begin
      int extra;
      checks        = 0;
      passes        = 0;
      rst_n         = 1'b0;
      i_cw_in       = '0;
      i_cw_valid    = 1'b0;
      i_err_cnt_clr = 1'b0;
      tick();
      tick();
      check("reset busy", {31'h0, o_busy}, 32'h0);
      check("reset dv", {31'h0, o_data_valid}, 32'h0);
      check("reset err", {31'h0, o_crc_err}, 32'h0);
      check("reset data", {16'h0, o_data_out}, 32'h0);
`ifdef CRC_ERR_CNT_EN
      check("reset err_cnt", {16'h0, o_err_cnt}, 32'h0);
`endif
      rst_n = 1'b1;
      tick();

      run_word("w1", 32'h0001_1021, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_word("w3", 32'h0003_3063, 16'h0003, 1'b0, 1'b0, 1'b0);
      run_word("bad", 32'h0001_1020, 16'h0001, 1'b1, 1'b0, 1'b0);
      run_word("ign", 32'h0002_2042, 16'h0002, 1'b0, 1'b1, 1'b0);

      // Abort mid-SHIFT with an asynchronous reset pulse.
      i_cw_in    = 32'h0001_1020;
      i_cw_valid = 1'b1;
      tick();
      i_cw_valid = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      rst_n = 1'b0;
      #1;
      check("abort busy", {31'h0, o_busy}, 32'h0);
      check("abort data", {16'h0, o_data_out}, 32'h0);
      check("abort err", {31'h0, o_crc_err}, 32'h0);
      tick();
      rst_n = 1'b1;
      extra = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (o_data_valid === 1'b1) extra++;
      end
      check("abort no_report", extra, 0);
      check("abort busy_after", {31'h0, o_busy}, 32'h0);

      run_word("zero", 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b0);

`ifdef CRC_ERR_CNT_EN
      run_word("cnt1", 32'h0001_1020, 16'h0001, 1'b1, 1'b0, 1'b0);
      run_word("cnt2", 32'h0001_1020, 16'h0001, 1'b1, 1'b0, 1'b0);
      run_word("cnt3", 32'h0001_1020, 16'h0001, 1'b1, 1'b0, 1'b0);
      check("err_cnt three", {16'h0, o_err_cnt}, 32'd3);
      run_word("cnt4", 32'h0001_1020, 16'h0001, 1'b1, 1'b0, 1'b1);
      check("err_cnt cleared", {16'h0, o_err_cnt}, 32'd0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
